// File: rtl/fetch_pkg.sv
// Shared types and helpers for the F-stage fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Word-aligned and inside [base, base + 4*words); bound kept in 34 bits so it cannot wrap.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] words);
        logic [33:0] lim;
        lim = {2'b00, base} + {words, 2'b00};
        return (addr[1:0] == 2'b00) && (addr >= base) && ({2'b00, addr} < lim);
    endfunction

endpackage

// File: rtl/f_d_pipe_reg.sv
// F/D pipeline register: flush > load > bubble > hold.
module f_d_pipe_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        adel_in,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_valid,
    output logic        d_exc_adel
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        adel_q, adel_d;

    // Next-value selection; D_pc is kept on flush and bubble.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        adel_d  = adel_q;
        if (flush || (bubble && !load)) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            adel_d  = 1'b0;
        end else if (load) begin
            pc_d    = pc_in;
            instr_d = instr_in;
            valid_d = 1'b1;
            adel_d  = adel_in;
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            adel_q  <= adel_d;
        end
    end

    assign d_pc       = pc_q;
    assign d_instr    = instr_q;
    assign d_valid    = valid_q;
    assign d_exc_adel = adel_q;

endmodule

// File: rtl/f_fetch_unit.sv
// F-stage fetch unit: fetch PC, instruction-memory handshake FSM, F/D register.
module f_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] F_pc,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic        D_exc_adel
);

    fetch_state_e state_q, state_d;
    logic [31:0]  f_pc_q, f_pc_d;
    logic [31:0]  hold_q, hold_d;
    logic         legal;
    logic         fire;
    logic [31:0]  fire_instr;
    logic         fire_adel;

    assign legal   = addr_legal(f_pc_q, IM_BASE, 32'(IM_WORDS));
    assign im_req  = (state_q == ST_REQ) && legal;
    assign im_addr = f_pc_q;
    assign F_pc    = f_pc_q;

    // Next-state, fire decision and F_pc update; flush overrides everything below reset.
    always_comb begin
        state_d    = state_q;
        f_pc_d     = f_pc_q;
        hold_d     = hold_q;
        fire       = 1'b0;
        fire_instr = NOP_INSTR;
        fire_adel  = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (!legal) begin
                    if (!stall) begin
                        fire      = 1'b1;
                        fire_adel = 1'b1;
                    end
                end else if (im_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (im_rvalid) begin
                    if (!stall) begin
                        fire       = 1'b1;
                        fire_instr = im_rdata;
                        state_d    = ST_REQ;
                    end else begin
                        hold_d  = im_rdata;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    fire       = 1'b1;
                    fire_instr = hold_q;
                    state_d    = ST_REQ;
                end
            end
            ST_DROP: begin
                if (im_rvalid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
        if (fire) f_pc_d = next_pc;
        if (flush) begin
            fire    = 1'b0;
            f_pc_d  = flush_pc;
            hold_d  = '0;
            state_d = (state_q == ST_WAIT && !im_rvalid) ? ST_DROP : ST_REQ;
        end
    end

    // State, fetch PC and hold buffer registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_REQ;
            f_pc_q  <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            f_pc_q  <= f_pc_d;
            hold_q  <= hold_d;
        end
    end

    f_d_pipe_reg u_fd (
        .clk        (clk),
        .reset      (reset),
        .load       (fire),
        .bubble     (!stall && !fire),
        .flush      (flush),
        .pc_in      (f_pc_q),
        .instr_in   (fire_instr),
        .adel_in    (fire_adel),
        .d_pc       (D_pc),
        .d_instr    (D_instr),
        .d_valid    (D_valid),
        .d_exc_adel (D_exc_adel)
    );

endmodule

// File: tb/tb_f_fetch_unit.sv
// Self-checking bench for f_fetch_unit: memory responder, delivery scoreboard, directed phases.
module tb_f_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] next_pc;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic [31:0] F_pc;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic        D_valid;
    logic        D_exc_adel;

    int n_vec = 0;
    int n_miss = 0;

    f_fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .IM_BASE  (32'h0000_3000),
        .IM_WORDS (4096)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .next_pc    (next_pc),
        .stall      (stall),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_gnt     (im_gnt),
        .im_rvalid  (im_rvalid),
        .im_rdata   (im_rdata),
        .F_pc       (F_pc),
        .D_pc       (D_pc),
        .D_instr    (D_instr),
        .D_valid    (D_valid),
        .D_exc_adel (D_exc_adel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return ((addr - 32'h0000_3000) >> 2) + 32'h0000_000A;
    endfunction

    // Program flow: sequential except for a few hand-placed jumps into illegal space.
    always_comb begin
        case (F_pc)
            32'h0000_3104: next_pc = 32'h0000_3002;
            32'h0000_3002: next_pc = 32'h0000_2FFC;
            32'h0000_2FFC: next_pc = 32'h0000_3200;
            default:       next_pc = F_pc + 32'd4;
        endcase
    end

    // ---------------- memory responder ----------------
    bit          mem_en = 1'b0;
    int unsigned gnt_dly = 0;
    int unsigned rv_dly = 1;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] held_addr = '0;
    int unsigned wait_cnt = 0;
    int unsigned req_wait = 0;
    bit          force_data = 1'b0;
    logic [31:0] force_val = '0;

    assign im_gnt    = im_req && !pend && mem_en && (req_wait >= gnt_dly);
    assign im_rvalid = pend && (wait_cnt >= rv_dly);
    assign im_rdata  = !pend ? 32'hDEAD_BEEF : (force_data ? force_val : word_of(pend_addr));

    always @(posedge clk) begin
        if (!reset) begin
            pend     <= 1'b0;
            wait_cnt <= 0;
            req_wait <= 0;
        end else begin
            if (im_req && im_gnt) begin
                pend      <= 1'b1;
                pend_addr <= im_addr;
                wait_cnt  <= 1;
            end else if (im_rvalid) begin
                pend     <= 1'b0;
                wait_cnt <= 0;
            end else if (pend) begin
                wait_cnt <= wait_cnt + 1;
            end
            req_wait  <= (im_req && !im_gnt && mem_en) ? req_wait + 1 : 0;
            held_addr <= im_addr;
        end
    end

    // Protocol checks: one outstanding request, request stable until granted.
    always @(negedge clk) begin
        if (reset) begin
            if (pend) chk("one_outstanding", 32'(im_req), 32'd0);
            if (req_wait > 0) begin
                chk("req_held", 32'(im_req), 32'd1);
                chk("addr_held", im_addr, held_addr);
            end
        end
    end

    // ---------------- delivery scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   mon_live;
    bit   mon_flush;
    int   cyc = 0;
    bit   chk_spacing = 1'b0;
    bit   have_last = 1'b0;
    int   last_cyc = 0;

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic adel);
        exp_t e;
        e.pc = pc;
        e.instr = instr;
        e.adel = adel;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        mon_live  = reset && !stall && !flush;
        mon_flush = reset && flush;
        cyc++;
        #1;
        if (mon_flush) begin
            chk("flush_dvalid", 32'(D_valid), 32'd0);
            chk("flush_dinstr", D_instr, 32'd0);
            chk("flush_dadel", 32'(D_exc_adel), 32'd0);
        end else if (mon_live) begin
            if (D_valid) begin
                chk("have_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("d_pc", D_pc, mon_e.pc);
                    chk("d_instr", D_instr, mon_e.instr);
                    chk("d_adel", 32'(D_exc_adel), 32'(mon_e.adel));
                end
                if (chk_spacing && have_last) chk("fetch_spacing", 32'(cyc - last_cyc), 32'd2);
                have_last = 1'b1;
                last_cyc  = cyc;
            end else begin
                chk("bubble_instr", D_instr, 32'd0);
                chk("bubble_adel", 32'(D_exc_adel), 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_until_empty(input int max_cyc, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_grant(input int max_cyc, input string tag);
        int n = 0;
        while (!pend && n < max_cyc) begin
            tick();
            n++;
        end
        chk({tag, "_granted"}, 32'(pend), 32'd1);
    endtask

    task automatic wait_fpc(input logic [31:0] pc, input int max_cyc, input string tag);
        int n = 0;
        while (F_pc !== pc && n < max_cyc) begin
            tick();
            n++;
        end
        chk({tag, "_fpc"}, F_pc, pc);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_fpc"}, F_pc, 32'h0000_3000);
        chk({tag, "_dpc"}, D_pc, 32'd0);
        chk({tag, "_dinstr"}, D_instr, 32'd0);
        chk({tag, "_dvalid"}, 32'(D_valid), 32'd0);
        chk({tag, "_dadel"}, 32'(D_exc_adel), 32'd0);
        chk({tag, "_imreq"}, 32'(im_req), 32'd1);
        chk({tag, "_imaddr"}, im_addr, 32'h0000_3000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- directed phases ----------------
    initial begin
        int n;

        // Reset values
        repeat (3) tick();
        check_reset_state("reset");
        reset = 1'b1;

        // Zero-wait memory: 4 sequential fetches, one every 2 cycles
        gnt_dly = 0;
        rv_dly  = 1;
        for (int unsigned i = 0; i < 4; i++)
            push(32'h0000_3000 + 32'(4 * i), 32'h0000_000A + 32'(i), 1'b0);
        chk_spacing = 1'b1;
        have_last   = 1'b0;
        mem_en      = 1'b1;
        run_until_empty(50, "zw");
        mem_en      = 1'b0;
        chk_spacing = 1'b0;
        chk("zw_fpc", F_pc, 32'h0000_3010);

        // Stall raised with the response: captured into HOLD, delivered on release
        force_data = 1'b1;
        force_val  = 32'h0000_1234;
        rv_dly     = 2;
        mem_en     = 1'b1;
        wait_grant(20, "stall");
        mem_en = 1'b0;
        n = 0;
        while (!im_rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("stall_rvalid_seen", 32'(im_rvalid), 32'd1);
        stall = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            chk("stall_fpc", F_pc, 32'h0000_3010);
            chk("stall_dpc", D_pc, 32'h0000_300C);
            chk("stall_dvalid", 32'(D_valid), 32'd0);
            chk("stall_dinstr", D_instr, 32'd0);
        end
        push(32'h0000_3010, 32'h0000_1234, 1'b0);
        stall = 1'b0;
        run_until_empty(10, "stall");
        force_data = 1'b0;

        // Flush while waiting: in-flight response dropped, refetch at target
        rv_dly = 3;
        mem_en = 1'b1;
        wait_grant(20, "flush");
        flush    = 1'b1;
        flush_pc = 32'h0000_3100;
        tick();
        flush = 1'b0;
        chk("flush_fpc", F_pc, 32'h0000_3100);
        chk("flush_noreq", 32'(im_req), 32'd0);
        push(32'h0000_3100, word_of(32'h0000_3100), 1'b0);
        n = 0;
        while (!im_req && n < 20) begin
            tick();
            n++;
        end
        chk("flush_req_seen", 32'(im_req), 32'd1);
        chk("flush_imaddr", im_addr, 32'h0000_3100);
        run_until_empty(20, "flush");
        mem_en = 1'b0;

        // Illegal fetch addresses: misaligned, then below IM_BASE
        rv_dly = 1;
        push(32'h0000_3104, word_of(32'h0000_3104), 1'b0);
        push(32'h0000_3002, 32'd0, 1'b1);
        push(32'h0000_2FFC, 32'd0, 1'b1);
        mem_en = 1'b1;
        wait_grant(20, "adel");
        mem_en = 1'b0;
        wait_fpc(32'h0000_3002, 10, "adel_mis");
        chk("adel_mis_noreq", 32'(im_req), 32'd0);
        wait_fpc(32'h0000_2FFC, 10, "adel_low");
        chk("adel_low_noreq", 32'(im_req), 32'd0);
        run_until_empty(10, "adel");
        chk("adel_fpc", F_pc, 32'h0000_3200);

        // Reset asserted for one cycle while a request is outstanding
        rv_dly = 3;
        mem_en = 1'b1;
        wait_grant(20, "rstmid");
        mem_en = 1'b0;
        reset  = 1'b0;
        tick();
        check_reset_state("rstmid");
        reset = 1'b1;
        tick();
        chk("rstmid_req_after", 32'(im_req), 32'd1);
        chk("rstmid_addr_after", im_addr, 32'h0000_3000);

        // Slow memory: 4-cycle grant delay, 3-cycle response delay, 20 fetches
        gnt_dly = 4;
        rv_dly  = 3;
        for (int unsigned i = 0; i < 20; i++)
            push(32'h0000_3000 + 32'(4 * i), word_of(32'h0000_3000 + 32'(4 * i)), 1'b0);
        mem_en = 1'b1;
        run_until_empty(400, "slow");
        mem_en = 1'b0;
        chk("slow_fpc", F_pc, 32'h0000_3050);

        repeat (3) tick();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/f_fetch_unit.md
Name: f_fetch_unit

Overview:
- F-stage fetch unit of the pipelined MIPS core.
- Owns the architectural fetch PC (F_pc) and drives the instruction-memory request/response handshake.
- Loads the F/D pipeline register (D_pc, D_instr, D_valid, D_exc_adel).
- Consumes the next-PC value computed by the D-stage next-PC logic and feeds F_pc and D_pc back to it.

Parameters:
- RESET_PC, 32'h0000_3000, F_pc value after reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 4096, number of legal instruction words starting at IM_BASE.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset); sampled on the rising edge of clk.
- next_pc  in  32  PC to fetch after the current one; from D-stage next-PC logic.
- stall  in  1  hazard stall; hold F_pc and the F/D register.
- flush  in  1  redirect request; overrides stall.
- flush_pc  in  32  redirect target, used when flush=1.
- im_req  out  1  instruction-memory request valid.
- im_addr  out  32  request address, equal to F_pc.
- im_gnt  in  1  request accepted this cycle.
- im_rvalid  in  1  response data valid.
- im_rdata  in  32  response instruction word.
- F_pc  out  32  current fetch PC.
- D_pc  out  32  PC of the instruction held in D.
- D_instr  out  32  instruction held in D; 0 (nop) when invalid.
- D_valid  out  1  D holds a real instruction.
- D_exc_adel  out  1  D instruction faulted on fetch (AdEL).

Behaviour:
- Reset (reset=0 at the edge), regardless of state:
  - F_pc=RESET_PC, state=REQ.
  - D_pc=0, D_instr=0, D_valid=0, D_exc_adel=0, hold buffer cleared.
  - Memory shares the reset, so no response is outstanding after reset.
- im_addr=F_pc at all times.
- im_req=1 only in state REQ when the address is legal.
- Legal address: F_pc[1:0]==0 and IM_BASE <= F_pc < IM_BASE+4*IM_WORDS.
- States:
  - REQ:
    - Illegal F_pc: no request; fault word is available immediately (instr=0, adel=1).
    - Legal F_pc, im_gnt=1: go to WAIT.
    - im_rvalid in REQ is ignored.
  - WAIT:
    - im_rvalid=1 and stall=0: fire; go to REQ.
    - im_rvalid=1 and stall=1: capture im_rdata into the hold buffer; go to HOLD.
  - HOLD:
    - stall=0: fire from the buffer; go to REQ.
  - DROP:
    - Discard the next im_rvalid response, then go to REQ.
- Fire (instruction delivered to D):
  - D_pc<=F_pc, D_instr<=word, D_exc_adel<=fault, D_valid<=1, F_pc<=next_pc.
- No fire and stall=0: D becomes a bubble (D_valid=0, D_instr=0, D_exc_adel=0; D_pc unchanged).
- stall=1 and flush=0: F_pc and all D outputs hold.
- flush=1 (highest priority below reset):
  - F_pc<=flush_pc, D_valid<=0, D_instr<=0, D_exc_adel<=0.
  - From WAIT without im_rvalid that cycle: go to DROP.
  - From WAIT with im_rvalid that cycle: the response is discarded; go to REQ.
  - From any other state: go to REQ.
  - Hold buffer invalidated.
- Latency:
  - Memory asserts im_rvalid at least 1 cycle after im_gnt.
  - One request outstanding at most.
  - Zero-wait memory gives 1 instruction per 2 cycles.
- The branch delay slot is architectural; a taken branch does not flush the F/D register.
- next_pc is sampled only on a fire edge.

Decomposition:
- Package fetch_pkg:
  - state encoding {REQ, WAIT, HOLD, DROP}, 2 bits.
  - NOP_INSTR=32'h0.
  - Legal-address range check as a function of IM_BASE and IM_WORDS.
- One sub-module, f_d_pipe_reg: the F/D register with load/bubble/hold/flush controls.
- The fetch FSM and F_pc register stay in the top module.

Test Plan:
- Reset then zero-wait memory (gnt with req, rvalid next cycle), next_pc=F_pc+4, words 0xA..0xD -> F_pc 0x3000,0x3004,... advancing every 2 cycles; D_instr sequence 0xA,0xB,... with D_valid=1 on the cycle after each rvalid.
- stall=1 asserted in the same cycle as im_rvalid(0x1234), held 3 cycles -> state HOLD, F_pc and D outputs frozen; on stall release D_instr=0x1234, D_pc=old F_pc.
- flush=1 with flush_pc=0x3100 while in WAIT, response arriving 2 cycles later -> that response dropped; next im_addr=0x3100; D_valid=0 until the 0x3100 word fires.
- next_pc=0x3002 -> no im_req; next cycle D_exc_adel=1, D_instr=0, D_pc=0x3002. Repeat with next_pc=0x0000_2FFC (below IM_BASE) -> same fault result.
- reset=0 asserted mid-WAIT for 1 cycle -> all outputs return to reset values and F_pc=0x3000 on that edge; next request at 0x3000.
- Memory with a 4-cycle gnt delay and 3-cycle rvalid delay -> im_req held steady with a constant im_addr until gnt; exactly one request outstanding; no instruction lost or duplicated over 20 fetches.
